register_file_32x32: RTL

- Architectural register file of the single-cycle MIPS datapath: 32 entries × 32 bits.
- Two combinational read ports feed the ALU operand inputs (rs/rt).
- One synchronous write port consumes the ALU result, or the memory/link data selected by the write-back mux.
- Register $0 is hardwired to zero.
- Optional same-cycle write-to-read bypass, for use when the block is reused in a pipelined variant.

---
 rtl/register_file_32x32.sv | 75 +++++++
 1 files changed

// File: rtl/register_file_32x32.sv
// rtl/register_file_32x32.sv - 32x32 MIPS register file, two combinational reads, one synchronous write
//
// Purpose: architectural register file for the single-cycle MIPS datapath.
//   Entry 0 is hardwired to zero. An optional write-to-read bypass can be enabled
//   for reuse in a pipelined datapath.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst_n           synchronous active-low reset
//   read_reg1/2     read port addresses (rs / rt)
//   write_reg       write-back destination address
//   write_data      write-back value
//   reg_write       write enable
//   read_data1/2    combinational read data
//   zero_write_err  sticky flag, set when a write to $0 is attempted; cleared by reset

module register_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              zero_write_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Reset wins over a concurrent write. The write path is gated by reg_write
    // first, so write_reg contents are irrelevant while reg_write is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            zero_write_err <= 1'b0;
        end else if (reg_write) begin
            if (write_reg == '0) begin
                zero_write_err <= 1'b1;
            end else begin
                regs[write_reg] <= write_data;
            end
        end
    end

    // Address 0 is forced to zero ahead of the bypass check, so a $0 write is
    // never forwarded. A nonzero address match implies write_reg is nonzero.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        data = '0;
        if (addr != '0) begin
            if ((BYPASS != 0) && reg_write && (write_reg == addr)) begin
                data = write_data;
            end else begin
                data = regs[addr];
            end
        end
        return data;
    endfunction

    always_comb begin
        read_data1 = read_port(read_reg1);
        read_data2 = read_port(read_reg2);
    end

endmodule
